// File: rtl/rat_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rat_ctrl_pkg
// Purpose  : Shared types and constants for the RAT MCU program-flow control.
//            Holds the instruction class encoding, the sequencer state
//            encoding, the PC mux select codes and the interrupt vector.
// Ports    : none (package)
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
package rat_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_OTHER  = 3'd0,
        OP_BRANCH = 3'd1,
        OP_CALL   = 3'd2,
        OP_RET    = 3'd3,
        OP_RETIE  = 3'd4,
        OP_RETID  = 3'd5,
        OP_SEI    = 3'd6,
        OP_CLI    = 3'd7
    } op_class_t;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_INTR  = 2'd3
    } state_t;

    localparam logic [1:0] PCSEL_IR  = 2'd0;
    localparam logic [1:0] PCSEL_STK = 2'd1;
    localparam logic [1:0] PCSEL_VEC = 2'd2;

    localparam logic [9:0] INTR_VECTOR = 10'h3FF;

endpackage : rat_ctrl_pkg
`default_nettype wire

// File: rtl/stack_pointer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : stack_pointer
// Purpose  : SP_W-bit stack pointer register with modular increment and
//            decrement. Also exposes SP-1, the address a push writes to.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            inc, dec        - step SP up / down (never both at once)
//            sp              - current stack pointer
//            sp_minus1       - SP-1 (modulo 2^SP_W)
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module stack_pointer #(
    parameter int SP_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            dec,
    output logic [SP_W-1:0] sp,
    output logic [SP_W-1:0] sp_minus1
);

    localparam logic [SP_W-1:0] C_ONE = {{(SP_W-1){1'b0}}, 1'b1};

    logic [SP_W-1:0] sp_reg;

    // Wraparound in both directions falls out of the fixed-width arithmetic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_reg <= '0;
        end else if (inc) begin
            sp_reg <= sp_reg + C_ONE;
        end else if (dec) begin
            sp_reg <= sp_reg - C_ONE;
        end
    end

    assign sp        = sp_reg;
    assign sp_minus1 = sp_reg - C_ONE;

endmodule : stack_pointer
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pc_sequencer
// Purpose  : Program-flow controller for the RAT MCU. Steps each instruction
//            through FETCH/EXEC, decides how the PC is updated, owns the stack
//            pointer, the stack write strobe and the interrupt-enable flag.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            op_class        - decoded class of the current instruction
//            cond_true       - branch condition met (valid in EXEC)
//            intr            - level interrupt request, synchronous to clk
//            pc_ld, pc_inc   - PC load / increment strobes
//            pc_mux_sel      - PC source: IR target, stack data, vector
//            stk_we          - write PC into scratch RAM at stk_addr
//            stk_addr        - scratch RAM address for stack accesses
//            sp              - current stack pointer
//            i_en            - interrupt enable flag
//            state           - current sequencer state (debug)
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module pc_sequencer
    import rat_ctrl_pkg::*;
#(
    parameter int SP_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      op_class,
    input  logic            cond_true,
    input  logic            intr,
    output logic            pc_ld,
    output logic            pc_inc,
    output logic [1:0]      pc_mux_sel,
    output logic            stk_we,
    output logic [SP_W-1:0] stk_addr,
    output logic [SP_W-1:0] sp,
    output logic            i_en,
    output logic [1:0]      state
);

    state_t          cur_state;
    state_t          nxt_state;
    op_class_t       op;
    logic [SP_W-1:0] sp_minus1;
    logic            sp_inc;
    logic            sp_dec;
    logic            ien_set;
    logic            ien_clr;
    logic            ien_reg;

    assign op = op_class_t'(op_class);

    stack_pointer #(
        .SP_W (SP_W)
    ) u_stack_pointer (
        .clk       (clk),
        .rst       (rst),
        .inc       (sp_inc),
        .dec       (sp_dec),
        .sp        (sp),
        .sp_minus1 (sp_minus1)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= ST_INIT;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic. The interrupt decision uses the I_EN value held before
    // this EXEC edge, so SEI/RETIE take effect one instruction later and CLI
    // cannot block a request that is already pending.
    always_comb begin
        nxt_state = ST_FETCH;
        case (cur_state)
            ST_INIT:  nxt_state = ST_FETCH;
            ST_FETCH: nxt_state = ST_EXEC;
            ST_EXEC:  nxt_state = (intr && ien_reg) ? ST_INTR : ST_FETCH;
            ST_INTR:  nxt_state = ST_FETCH;
            default:  nxt_state = ST_INIT;
        endcase
    end

    // Output logic
    always_comb begin
        pc_ld      = 1'b0;
        pc_inc     = 1'b0;
        pc_mux_sel = PCSEL_IR;
        stk_we     = 1'b0;
        stk_addr   = sp;
        sp_inc     = 1'b0;
        sp_dec     = 1'b0;
        ien_set    = 1'b0;
        ien_clr    = 1'b0;
        case (cur_state)
            ST_FETCH: begin
                pc_inc = 1'b1;
            end
            ST_EXEC: begin
                case (op)
                    OP_BRANCH: begin
                        pc_ld = cond_true;
                    end
                    OP_CALL: begin
                        // Push goes to SP-1 so the stack grows downward.
                        stk_we   = 1'b1;
                        stk_addr = sp_minus1;
                        sp_dec   = 1'b1;
                        pc_ld    = 1'b1;
                    end
                    OP_RET, OP_RETIE, OP_RETID: begin
                        pc_ld      = 1'b1;
                        pc_mux_sel = PCSEL_STK;
                        sp_inc     = 1'b1;
                        ien_set    = (op == OP_RETIE);
                        ien_clr    = (op == OP_RETID);
                    end
                    OP_SEI:  ien_set = 1'b1;
                    OP_CLI:  ien_clr = 1'b1;
                    default: ;
                endcase
            end
            ST_INTR: begin
                stk_we     = 1'b1;
                stk_addr   = sp_minus1;
                sp_dec     = 1'b1;
                pc_ld      = 1'b1;
                pc_mux_sel = PCSEL_VEC;
                ien_clr    = 1'b1;
            end
            default: ;
        endcase
    end

    // Interrupt enable flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ien_reg <= 1'b0;
        end else if (ien_set) begin
            ien_reg <= 1'b1;
        end else if (ien_clr) begin
            ien_reg <= 1'b0;
        end
    end

    assign i_en  = ien_reg;
    assign state = cur_state;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_pc_sequencer
// Purpose  : Directed self-checking bench for pc_sequencer with hand-computed
//            expected values.
// Ports    : none
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int SP_W = 8;

    localparam logic [2:0] C_OTHER  = 3'd0;
    localparam logic [2:0] C_BRANCH = 3'd1;
    localparam logic [2:0] C_CALL   = 3'd2;
    localparam logic [2:0] C_RET    = 3'd3;
    localparam logic [2:0] C_RETIE  = 3'd4;
    localparam logic [2:0] C_SEI    = 3'd6;
    localparam logic [2:0] C_CLI    = 3'd7;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      op_class;
    logic            cond_true;
    logic            intr;
    logic            pc_ld;
    logic            pc_inc;
    logic [1:0]      pc_mux_sel;
    logic            stk_we;
    logic [SP_W-1:0] stk_addr;
    logic [SP_W-1:0] sp;
    logic            i_en;
    logic [1:0]      state;

    int n_checks = 0;
    int n_errors = 0;
    int intr_seen;

    pc_sequencer #(
        .SP_W (SP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .op_class   (op_class),
        .cond_true  (cond_true),
        .intr       (intr),
        .pc_ld      (pc_ld),
        .pc_inc     (pc_inc),
        .pc_mux_sel (pc_mux_sel),
        .stk_we     (stk_we),
        .stk_addr   (stk_addr),
        .sp         (sp),
        .i_en       (i_en),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock and settle away from the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst       = 1'b1;
        op_class  = C_OTHER;
        cond_true = 1'b0;
        intr      = 1'b0;
        #12;
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_sp", {24'd0, sp}, 32'h00);
        check("rst_ien", {31'd0, i_en}, 32'd0);
        check("rst_pcinc", {31'd0, pc_inc}, 32'd0);
        check("rst_stkaddr", {24'd0, stk_addr}, 32'h00);

        @(posedge clk);
        #2;
        rst = 1'b0;
        check("init_state", {30'd0, state}, 32'd0);
        step();
        check("fetch1_state", {30'd0, state}, 32'd1);
        check("fetch1_pcinc", {31'd0, pc_inc}, 32'd1);
        check("fetch1_pcld", {31'd0, pc_ld}, 32'd0);
        step();
        check("exec1_state", {30'd0, state}, 32'd2);
        check("exec1_pcinc", {31'd0, pc_inc}, 32'd0);
        check("exec1_pcld", {31'd0, pc_ld}, 32'd0);
        check("exec1_stkwe", {31'd0, stk_we}, 32'd0);
        step();
        check("fetch2_state", {30'd0, state}, 32'd1);

        // CALL from SP=0x00 wraps the push address to 0xFF
        op_class = C_CALL;
        check("call_fetch_stkwe", {31'd0, stk_we}, 32'd0);
        step();
        check("call_stkwe", {31'd0, stk_we}, 32'd1);
        check("call_stkaddr", {24'd0, stk_addr}, 32'hFF);
        check("call_pcld", {31'd0, pc_ld}, 32'd1);
        check("call_mux", {30'd0, pc_mux_sel}, 32'd0);
        check("call_sp_before", {24'd0, sp}, 32'h00);
        step();
        check("call_sp_after", {24'd0, sp}, 32'hFF);

        // RET pops from SP and wraps 0xFF back to 0x00
        op_class = C_RET;
        step();
        check("ret_stkaddr", {24'd0, stk_addr}, 32'hFF);
        check("ret_mux", {30'd0, pc_mux_sel}, 32'd1);
        check("ret_pcld", {31'd0, pc_ld}, 32'd1);
        check("ret_stkwe", {31'd0, stk_we}, 32'd0);
        step();
        check("ret_sp_after", {24'd0, sp}, 32'h00);

        // Branch not taken / taken
        op_class  = C_BRANCH;
        cond_true = 1'b0;
        step();
        check("br_nt_pcld", {31'd0, pc_ld}, 32'd0);
        step();
        cond_true = 1'b1;
        step();
        check("br_t_pcld", {31'd0, pc_ld}, 32'd1);
        check("br_t_mux", {30'd0, pc_mux_sel}, 32'd0);
        check("br_t_pcinc", {31'd0, pc_inc}, 32'd0);
        step();
        cond_true = 1'b0;

        // SEI with INTR high: no interrupt at this EXEC
        op_class = C_SEI;
        intr     = 1'b1;
        step();
        check("sei_exec_state", {30'd0, state}, 32'd2);
        step();
        check("sei_next_state", {30'd0, state}, 32'd1);
        check("sei_ien", {31'd0, i_en}, 32'd1);
        op_class = C_OTHER;
        step();
        step();
        check("intr_state", {30'd0, state}, 32'd3);
        check("intr_mux", {30'd0, pc_mux_sel}, 32'd2);
        check("intr_pcld", {31'd0, pc_ld}, 32'd1);
        check("intr_stkwe", {31'd0, stk_we}, 32'd1);
        check("intr_stkaddr", {24'd0, stk_addr}, 32'hFF);
        step();
        check("post_intr_state", {30'd0, state}, 32'd1);
        check("post_intr_ien", {31'd0, i_en}, 32'd0);
        check("post_intr_sp", {24'd0, sp}, 32'hFF);

        // RETIE with INTR still high: return first, no interrupt yet
        op_class = C_RETIE;
        step();
        check("retie_mux", {30'd0, pc_mux_sel}, 32'd1);
        step();
        check("retie_next_state", {30'd0, state}, 32'd1);
        check("retie_ien", {31'd0, i_en}, 32'd1);
        check("retie_sp", {24'd0, sp}, 32'h00);

        // CLI with I_EN=1 and INTR high: the old enable still lets it through
        op_class = C_CLI;
        step();
        step();
        check("cli_state", {30'd0, state}, 32'd3);
        check("cli_ien", {31'd0, i_en}, 32'd0);
        step();
        check("cli_sp", {24'd0, sp}, 32'hFF);

        // INTR held with I_EN=0 over 10 instructions: never enters INTR
        op_class  = C_OTHER;
        intr_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (state == 2'd3) intr_seen++;
            step();
            if (state == 2'd3) intr_seen++;
        end
        check("masked_intr_count", intr_seen, 0);
        check("masked_state", {30'd0, state}, 32'd1);

        // Bring SP to 0xFE, then reset in the middle of an INTR cycle
        op_class = C_CALL;
        intr     = 1'b0;
        step();
        step();
        check("call2_sp", {24'd0, sp}, 32'hFE);
        op_class = C_SEI;
        intr     = 1'b1;
        step();
        step();
        op_class = C_OTHER;
        step();
        step();
        check("intr2_state", {30'd0, state}, 32'd3);
        check("intr2_sp", {24'd0, sp}, 32'hFE);
        check("intr2_stkaddr", {24'd0, stk_addr}, 32'hFD);
        #1;
        rst = 1'b1;
        #1;
        check("arst_state", {30'd0, state}, 32'd0);
        check("arst_sp", {24'd0, sp}, 32'h00);
        check("arst_ien", {31'd0, i_en}, 32'd0);
        check("arst_stkwe", {31'd0, stk_we}, 32'd0);
        check("arst_pcld", {31'd0, pc_ld}, 32'd0);
        @(posedge clk);
        #2;
        rst  = 1'b0;
        intr = 1'b0;
        step();
        check("rerun_state", {30'd0, state}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire
